rm1000_sub_sched: RTL



---
 rtl/rm1000_sub_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rm1000_sub_sched.sv
// Round-robin scheduler granting the shared rootModule1000 sub-block to one of NUM_REQ requesters.
// Optional watchdog release enabled by defining RM1000_SCHED_TIMEOUT_EN.
module rm1000_sub_sched #(
  parameter int NUM_REQ        = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_id,
  output logic               start,
  output logic               busy,
  output logic               timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("rm1000_sub_sched: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         gnt_id_q, gnt_id_d;
  logic [2:0]         ptr_q, ptr_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               sel_vld;
  logic [2:0]         sel_id;
  logic [2:0]         next_ptr;
  logic               expire;
  logic               release_c;

  // Scan downward so the lowest offset from ptr (first in round-robin order) wins.
  always_comb begin
    logic [3:0] idx;
    idx     = '0;
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + 4'(i);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (req[idx[2:0]]) begin
        sel_vld = 1'b1;
        sel_id  = idx[2:0];
      end
    end
  end

  assign next_ptr  = (gnt_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_id_q + 3'd1;
  assign release_c = done || expire;

`ifdef RM1000_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_START)     cnt_d = '0;
    else if (state_q == S_BUSY) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // done on the expiry cycle takes precedence and suppresses the error pulse.
  assign expire = (state_q == S_BUSY) && (cnt_q == TO_LAST) && !done;
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:          if (sel_vld) state_d = S_START;
      S_START, S_BUSY: state_d = release_c ? S_IDLE : S_BUSY;
      default:         state_d = S_IDLE;
    endcase
  end

  // Output flops load the values for the state being entered, so they line up with state_q.
  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    start_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = 1'b0;
    if (state_q == S_IDLE) begin
      if (sel_vld) begin
        gnt_d    = NUM_REQ'(1) << sel_id;
        gnt_id_d = sel_id;
        start_d  = 1'b1;
        busy_d   = 1'b1;
      end
    end else if (release_c) begin
      gnt_d    = '0;
      gnt_id_d = '0;
      busy_d   = 1'b0;
      ptr_d    = next_ptr;
      err_d    = expire;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
